// File: rtl/abr_ntt_add_sub_lanes.sv
// Multi-lane pipelined modular add/sub: res[k] = (opa[k] +/- opb[k]) mod prime.
// Two register stages (S1 operand/partial sum, S2 output) with valid/ready
// backpressure; per-lane sub select; per-bundle MLKEM (12-bit) / MLDSA mode.
// Ports: clk, reset_n (sync, active-low), zeroize, in_valid_i/in_ready_o,
//   sub_i, mlkem_i, opa_i, opb_i, prime_i, out_valid_o/out_ready_i, res_o, err_o.
// Optional: define ABR_NTT_ADDSUB_RANGE_CHK_EN to flag inputs >= prime on err_o.
module abr_ntt_add_sub_lanes #(
   parameter int NUM_LANES      = 4,
   parameter int REG_SIZE       = 24,
   parameter int MLKEM_REG_SIZE = 12
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          zeroize,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [NUM_LANES-1:0]          sub_i,
   input  logic                          mlkem_i,
   input  logic [NUM_LANES*REG_SIZE-1:0] opa_i,
   input  logic [NUM_LANES*REG_SIZE-1:0] opb_i,
   input  logic [REG_SIZE-1:0]           prime_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [NUM_LANES*REG_SIZE-1:0] res_o,
   output logic [NUM_LANES-1:0]          err_o
);

   localparam int W = REG_SIZE;
   localparam int K = MLKEM_REG_SIZE;
   localparam int L = NUM_LANES;
   localparam logic [W-1:0] MASK_K = {{(W-K){1'b0}}, {K{1'b1}}};
   localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

   logic                s1_valid;
   logic                s1_mlkem;
   logic [L-1:0]        s1_sub;
   logic [L-1:0]        s1_c0;
   logic [L-1:0][W-1:0] s1_r0;
   logic [L-1:0][W-1:0] s1_cor;
   logic                out_valid_q;
   logic [L-1:0][W-1:0] res_q;

   logic [L-1:0]        c0_d;
   logic [L-1:0][W-1:0] r0_d;
   logic [L-1:0][W-1:0] cor_d;
   logic [L-1:0][W-1:0] res_d;

   logic out_adv;
   logic s1_adv;

   assign out_adv    = !out_valid_q | out_ready_i;
   assign s1_adv     = !s1_valid | out_adv;
   assign in_ready_o = s1_adv;

   for (genvar k = 0; k < L; k++) begin : g_lane
      logic [W-1:0] mk, a, b, p, nb, mk2;
      logic [W:0]   sum, s2;
      logic         c1;

      // Mode mask keeps MLKEM arithmetic to 12 bits so the carry lands on bit 12.
      assign mk  = mlkem_i ? MASK_K : '1;
      assign a   = opa_i[k*W +: W] & mk;
      assign b   = opb_i[k*W +: W] & mk;
      assign p   = prime_i & mk;
      assign nb  = ~b & mk;
      assign sum = {1'b0, a} + {1'b0, (sub_i[k] ? nb : b)}
                 + {{W{1'b0}}, sub_i[k]};

      assign c0_d[k]  = mlkem_i ? sum[K] : sum[W];
      assign r0_d[k]  = sum[W-1:0] & mk;
      assign cor_d[k] = (sub_i[k] ? p : (~p + ONE_W)) & mk;

      // Add: carry from r0 + (-q) (or from the first sum) means r0 >= q.
      // Sub: missing carry on opa + ~opb + 1 means a borrow, so add q back.
      assign mk2 = s1_mlkem ? MASK_K : '1;
      assign s2  = {1'b0, s1_r0[k]} + {1'b0, s1_cor[k]};
      assign c1  = s1_mlkem ? s2[K] : s2[W];

      assign res_d[k] = ((s1_sub[k] ? !s1_c0[k] : (s1_c0[k] | c1))
                         ? s2[W-1:0] : s1_r0[k]) & mk2;
   end

`ifdef ABR_NTT_ADDSUB_RANGE_CHK_EN
   logic [L-1:0] err_d;
   logic [L-1:0] s1_err;
   logic [L-1:0] err_q;

   for (genvar k = 0; k < L; k++) begin : g_chk
      assign err_d[k] = (g_lane[k].a >= g_lane[k].p)
                      | (g_lane[k].b >= g_lane[k].p);
   end

   always_ff @(posedge clk) begin
      if (!reset_n || zeroize) begin
         s1_err <= '0;
         err_q  <= '0;
      end else begin
         if (s1_adv && in_valid_i) s1_err <= err_d;
         if (out_adv && s1_valid)  err_q  <= s1_err;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = '0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n || zeroize) begin
         s1_valid    <= 1'b0;
         s1_mlkem    <= 1'b0;
         s1_sub      <= '0;
         s1_c0       <= '0;
         s1_r0       <= '0;
         s1_cor      <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
               s1_mlkem <= mlkem_i;
               s1_sub   <= sub_i;
               s1_c0    <= c0_d;
               s1_r0    <= r0_d;
               s1_cor   <= cor_d;
            end
         end
         if (out_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) res_q <= res_d;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign res_o       = res_q;

endmodule

// File: tb/tb_abr_ntt_add_sub_lanes.sv
// Scoreboard bench for abr_ntt_add_sub_lanes: random and directed bundles,
// expected results from plain modular arithmetic, checked by a monitor.
module tb_abr_ntt_add_sub_lanes;

   localparam int NL = 4;
   localparam int W  = 24;

   typedef struct {
      logic [NL*W-1:0] res;
      logic [NL-1:0]   err;
      logic [NL-1:0]   care;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            zeroize = 1'b0;
   logic            in_valid_i = 1'b0;
   logic            in_ready_o;
   logic [NL-1:0]   sub_i = '0;
   logic            mlkem_i = 1'b0;
   logic [NL*W-1:0] opa_i = '0;
   logic [NL*W-1:0] opb_i = '0;
   logic [W-1:0]    prime_i = '0;
   logic            out_valid_o;
   logic            out_ready_i = 1'b1;
   logic [NL*W-1:0] res_o;
   logic [NL-1:0]   err_o;

   abr_ntt_add_sub_lanes dut (
      .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .sub_i(sub_i), .mlkem_i(mlkem_i), .opa_i(opa_i), .opb_i(opb_i),
      .prime_i(prime_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .res_o(res_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   rdy_mode = 0;
   int   win_lo   = 0;
   int   win_hi   = -1;
   bit   saw_bp   = 0;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name,
                        input logic [NL*W-1:0] act, input logic [NL*W-1:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   function automatic exp_t model(input logic [NL-1:0] sub, input logic mk,
                                  input logic [NL*W-1:0] a,
                                  input logic [NL*W-1:0] b,
                                  input logic [W-1:0] p);
      exp_t   e;
      longint q, av, bv, r;
      e.res  = '0;
      e.err  = '0;
      e.care = '0;
      q = mk ? longint'(p[11:0]) : longint'(p);
      for (int k = 0; k < NL; k++) begin
         av = mk ? longint'(a[k*W +: 12]) : longint'(a[k*W +: W]);
         bv = mk ? longint'(b[k*W +: 12]) : longint'(b[k*W +: W]);
         r  = sub[k] ? (av - bv + q) % q : (av + bv) % q;
         e.res[k*W +: W] = W'(r);
         e.care[k] = (av < q) && (bv < q);
`ifdef ABR_NTT_ADDSUB_RANGE_CHK_EN
         e.err[k] = !e.care[k];
`endif
      end
      return e;
   endfunction

   // out_ready generator: 0 always ready, 1 random, 2 held low, 3 low in window
   always @(negedge clk) begin
      case (rdy_mode)
         0: out_ready_i = 1'b1;
         1: out_ready_i = ($urandom % 4) != 0;
         2: out_ready_i = 1'b0;
         default: out_ready_i = !(cyc >= win_lo && cyc <= win_hi);
      endcase
   end

   // Monitor: pops on every output transfer; checks hold during stalls.
   logic [NL*W-1:0] prev_res;
   logic [NL-1:0]   prev_err;
   bit              prev_stall = 0;
   always @(negedge clk) begin
      #2;
      if (reset_n && !zeroize) begin
         if (prev_stall) begin
            check(out_valid_o === 1'b1, "stall_valid",
                  {95'b0, out_valid_o}, 96'd1);
            check(res_o === prev_res && err_o === prev_err, "stall_hold",
                  res_o, prev_res);
         end
         if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
               check(1'b0, "unexpected_out", res_o, '0);
            end else begin
               exp_t e;
               logic [NL*W-1:0] m;
               e = sb.pop_front();
               m = '0;
               for (int k = 0; k < NL; k++)
                  if (e.care[k]) m[k*W +: W] = '1;
               check((res_o & m) === (e.res & m), "res", res_o & m, e.res & m);
               check(err_o === e.err, "err", {92'b0, err_o}, {92'b0, e.err});
            end
         end
         prev_stall = out_valid_o && !out_ready_i;
         prev_res   = res_o;
         prev_err   = err_o;
      end else begin
         prev_stall = 0;
      end
   end

   task automatic drive(input logic v, input logic [NL-1:0] sub,
                        input logic mk, input logic [NL*W-1:0] a,
                        input logic [NL*W-1:0] b, input logic [W-1:0] p,
                        output bit acc);
      @(negedge clk);
      in_valid_i = v;
      sub_i      = sub;
      mlkem_i    = mk;
      opa_i      = a;
      opb_i      = b;
      prime_i    = p;
      #1;
      if (v && !in_ready_o) saw_bp = 1;
      acc = v && in_ready_o && !zeroize;
      if (acc) sb.push_back(model(sub, mk, a, b, p));
   endtask

   task automatic send(input logic [NL-1:0] sub, input logic mk,
                       input logic [NL*W-1:0] a, input logic [NL*W-1:0] b,
                       input logic [W-1:0] p);
      bit acc;
      for (int t = 0; t < 60; t++) begin
         drive(1'b1, sub, mk, a, b, p, acc);
         if (acc) return;
      end
      check(1'b0, "send_timeout", '0, 96'd1);
   endtask

   task automatic idle();
      bit acc;
      drive(1'b0, '0, 1'b0, '0, '0, '0, acc);
   endtask

   task automatic send_rand(input logic mk, input logic [W-1:0] p);
      logic [NL*W-1:0] a, b;
      logic [NL-1:0]   s;
      int              q;
      q = mk ? int'(p[11:0]) : int'(p);
      s = NL'($urandom);
      for (int k = 0; k < NL; k++) begin
         a[k*W +: W] = W'($urandom % q);
         b[k*W +: W] = W'($urandom % q);
         if ($urandom % 10 == 0) a[k*W +: W] = W'(q + int'($urandom % 2));
         if (mk) begin
            a[k*W+12 +: 12] = 12'($urandom);
            b[k*W+12 +: 12] = 12'($urandom);
         end
      end
      send(s, mk, a, b, p);
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && sb.size() != 0; t++) idle();
      check(sb.size() == 0, "drain", 96'(sb.size()), '0);
   endtask

   logic [W-1:0] dsa_p [3] = '{24'd8380417, 24'd7340033, 24'd65537};
   logic [W-1:0] kem_p [3] = '{24'd3329, 24'd4093, 24'd2053};

   initial begin
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      check(out_valid_o === 1'b0 && res_o === '0 && err_o === '0,
            "reset_out", res_o, '0);
      check(in_ready_o === 1'b1, "reset_ready", {95'b0, in_ready_o}, 96'd1);

      // 1: MLDSA directed plus latency
      send(4'b1010, 1'b0,
           {24'd100, 24'd5, 24'd0, 24'd8380416},
           {24'd100, 24'd7, 24'd1, 24'd1}, 24'd8380417);
      idle();
      check(out_valid_o === 1'b0, "lat_early", {95'b0, out_valid_o}, '0);
      idle();
      check(out_valid_o === 1'b1 &&
            res_o === {24'd0, 24'd12, 24'd8380416, 24'd0},
            "t1_res", res_o, {24'd0, 24'd12, 24'd8380416, 24'd0});

      // 2: MLKEM directed with junk in the unused upper bits
      send(4'b1010, 1'b1,
           {24'hABC000 | 24'd3328, 24'd0, 24'hFFF000 | 24'd5, 24'd3328},
           {24'd0, 24'h123000, 24'd3000, 24'h555000 | 24'd3328},
           24'hF00000 | 24'd3329);
      idle();
      idle();
      check(res_o === {24'd3328, 24'd0, 24'd334, 24'd3327},
            "t2_res", res_o, {24'd3328, 24'd0, 24'd334, 24'd3327});
      drain();

      // 3: stream 8 bundles with out_ready low in a window
      saw_bp = 0;
      win_lo = cyc + 3;
      win_hi = cyc + 6;
      rdy_mode = 3;
      for (int i = 0; i < 8; i++) send_rand(1'b0, 24'd8380417);
      drain();
      check(saw_bp == 1, "backpressure", {95'b0, saw_bp}, 96'd1);
      rdy_mode = 0;

      // 4: alternating modes and primes back-to-back
      for (int i = 0; i < 12; i++)
         if (i % 2 == 0) send_rand(1'b1, kem_p[i % 3]);
         else            send_rand(1'b0, dsa_p[i % 3]);
      drain();

      // 5: zeroize with two bundles in flight
      rdy_mode = 2;
      idle();
      send_rand(1'b0, 24'd8380417);
      send_rand(1'b1, 24'd3329);
      @(negedge clk);
      zeroize = 1'b1;
      in_valid_i = 1'b1;
      sb.delete();
      @(negedge clk);
      zeroize = 1'b0;
      in_valid_i = 1'b0;
      #1;
      check(out_valid_o === 1'b0 && res_o === '0, "zero_out", res_o, '0);
      check(in_ready_o === 1'b1, "zero_ready", {95'b0, in_ready_o}, 96'd1);
      rdy_mode = 0;
      send_rand(1'b0, 24'd7340033);
      idle();
      check(out_valid_o === 1'b0, "zero_lat_early", {95'b0, out_valid_o}, '0);
      idle();
      check(out_valid_o === 1'b1, "zero_lat", {95'b0, out_valid_o}, 96'd1);
      drain();

      // 6: range flag on lane1
      send(4'b0000, 1'b0, {24'd3, 24'd2, 24'd8380417, 24'd1},
           {24'd1, 24'd1, 24'd1, 24'd1}, 24'd8380417);
      drain();

      // random soak with random gaps and backpressure
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom % 4 == 0) idle();
         if ($urandom % 2 == 0) send_rand(1'b1, kem_p[$urandom % 3]);
         else                   send_rand(1'b0, dsa_p[$urandom % 3]);
      end
      rdy_mode = 0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
